// File: rtl/fp16_lcd_pkg.sv
// rtl/fp16_lcd_pkg.sv - shared state type, frame geometry and ASCII constants for fp16_lcd_formatter
package fp16_lcd_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } lcd_state_t;

   localparam logic [7:0] LINE1_ADDR  = 8'h80;
   localparam logic [7:0] LINE2_ADDR  = 8'hC0;
   localparam int         FRAME_BEATS = 34;
   localparam logic [5:0] LAST_BEAT   = 6'(FRAME_BEATS - 1);

   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_EQUALS  = 8'h3D;
   localparam logic [7:0] ASCII_PLUS    = 8'h2B;
   localparam logic [7:0] ASCII_MINUS   = 8'h2D;
   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_A       = 8'h41;
   localparam logic [7:0] ASCII_B       = 8'h42;
   localparam logic [7:0] ASCII_R       = 8'h52;
   localparam logic [7:0] ASCII_LOWER_A = 8'h61;

endpackage

// File: rtl/hex_to_ascii.sv
// rtl/hex_to_ascii.sv - combinational nibble to ASCII hex digit
// Ports:
//   nibble : 4-bit value 0..15
//   ascii  : '0'-'9', then 'A'-'F' (LOWER_HEX=0) or 'a'-'f' (LOWER_HEX=1)
module hex_to_ascii
   import fp16_lcd_pkg::*;
#(
   parameter int LOWER_HEX = 0
) (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) begin
         ascii = ASCII_ZERO + {4'h0, nibble};
      end else if (LOWER_HEX != 0) begin
         ascii = ASCII_LOWER_A - 8'd10 + {4'h0, nibble};
      end else begin
         ascii = ASCII_A - 8'd10 + {4'h0, nibble};
      end
   end

endmodule

// File: rtl/fp16_lcd_formatter.sv
// rtl/fp16_lcd_formatter.sv - renders an FP16 add/sub equation as a 34-beat two-line LCD frame
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start             : one-cycle frame request (ignored while busy)
//   operation         : 0 add ('+'), 1 subtract ('-')
//   A, B, R           : FP16 operand/result bit patterns, snapshotted at start
//   char_data         : ASCII character or LCD command byte of the current beat
//   char_is_cmd       : char_data is a command (RS=0)
//   char_valid/ready  : beat handshake with the downstream LCD driver
//   busy              : frame in progress
//   done              : one-cycle pulse after the last beat is accepted
module fp16_lcd_formatter
   import fp16_lcd_pkg::*;
#(
   parameter int LOWER_HEX = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        operation,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic [15:0] R,
   output logic [7:0]  char_data,
   output logic        char_is_cmd,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        busy,
   output logic        done
);

   lcd_state_t  state_q, state_d;
   logic [5:0]  beat_q;
   logic [15:0] snap_a, snap_b, snap_r;
   logic        snap_op;

   logic        accept;
   logic        last_accept;
   logic [5:0]  render_beat;
   logic [3:0]  nibble;
   logic [7:0]  hex_char;
   logic [7:0]  char_d;
   logic        cmd_d;

   assign accept      = char_valid && char_ready;
   assign last_accept = (state_q == ST_SEND) && accept && (beat_q == LAST_BEAT);
   assign busy        = (state_q == ST_SEND);

   // The output stage is loaded with the beat that will be shown next:
   // beat 0 when a frame starts, otherwise the one after the current beat.
   assign render_beat = (state_q == ST_SEND) ? beat_q + 6'd1 : 6'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_SEND;
         ST_SEND: if (last_accept) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      nibble = 4'h0;
      case (render_beat)
         6'd3:    nibble = snap_a[15:12];
         6'd4:    nibble = snap_a[11:8];
         6'd5:    nibble = snap_a[7:4];
         6'd6:    nibble = snap_a[3:0];
         6'd10:   nibble = snap_b[15:12];
         6'd11:   nibble = snap_b[11:8];
         6'd12:   nibble = snap_b[7:4];
         6'd13:   nibble = snap_b[3:0];
         6'd20:   nibble = snap_r[15:12];
         6'd21:   nibble = snap_r[11:8];
         6'd22:   nibble = snap_r[7:4];
         6'd23:   nibble = snap_r[3:0];
         default: nibble = 4'h0;
      endcase
   end

   hex_to_ascii #(.LOWER_HEX(LOWER_HEX)) u_hex (
      .nibble (nibble),
      .ascii  (hex_char)
   );

   always_comb begin
      char_d = ASCII_SPACE;
      cmd_d  = 1'b0;
      case (render_beat)
         6'd0: begin
            char_d = LINE1_ADDR;
            cmd_d  = 1'b1;
         end
         6'd1:                      char_d = ASCII_A;
         6'd8:                      char_d = ASCII_B;
         6'd18:                     char_d = ASCII_R;
         6'd2, 6'd9, 6'd19:         char_d = ASCII_EQUALS;
         6'd3, 6'd4, 6'd5, 6'd6,
         6'd10, 6'd11, 6'd12, 6'd13,
         6'd20, 6'd21, 6'd22, 6'd23: char_d = hex_char;
         6'd16:                     char_d = snap_op ? ASCII_MINUS : ASCII_PLUS;
         6'd17: begin
            char_d = LINE2_ADDR;
            cmd_d  = 1'b1;
         end
         default:                   char_d = ASCII_SPACE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_q      <= 6'd0;
         snap_a      <= 16'h0000;
         snap_b      <= 16'h0000;
         snap_r      <= 16'h0000;
         snap_op     <= 1'b0;
         char_data   <= 8'h00;
         char_is_cmd <= 1'b0;
         char_valid  <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  snap_a      <= A;
                  snap_b      <= B;
                  snap_r      <= R;
                  snap_op     <= operation;
                  beat_q      <= 6'd0;
                  char_data   <= char_d;
                  char_is_cmd <= cmd_d;
                  char_valid  <= 1'b1;
               end
            end
            ST_SEND: begin
               if (accept) begin
                  if (beat_q == LAST_BEAT) begin
                     beat_q      <= 6'd0;
                     char_data   <= 8'h00;
                     char_is_cmd <= 1'b0;
                     char_valid  <= 1'b0;
                     done        <= 1'b1;
                  end else begin
                     beat_q      <= render_beat;
                     char_data   <= char_d;
                     char_is_cmd <= cmd_d;
                  end
               end
            end
            default: char_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_lcd_formatter.sv
// tb/tb_fp16_lcd_formatter.sv - scoreboard bench for fp16_lcd_formatter (upper- and lower-case instances)
module tb_fp16_lcd_formatter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        operation = 1'b0;
   logic        char_ready = 1'b1;
   logic [15:0] A = 16'h0, B = 16'h0, R = 16'h0;

   logic [7:0]  data0, data1;
   logic        cmd0, cmd1, val0, val1, busy0, busy1, done0, done1;

   always #5 clk = ~clk;

   fp16_lcd_formatter #(.LOWER_HEX(0)) dut_upper (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .A(A), .B(B), .R(R),
      .char_data(data0), .char_is_cmd(cmd0), .char_valid(val0), .char_ready(char_ready),
      .busy(busy0), .done(done0)
   );

   fp16_lcd_formatter #(.LOWER_HEX(1)) dut_lower (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .A(A), .B(B), .R(R),
      .char_data(data1), .char_is_cmd(cmd1), .char_valid(val1), .char_ready(char_ready),
      .busy(busy1), .done(done1)
   );

   int          checks = 0;
   int          errors = 0;
   logic [9:0]  exp_q0[$];
   logic [9:0]  exp_q1[$];
   int          acc_cnt = 0;
   int          frame_base = 0;
   bit          stall_en = 0;
   int          stall_left = 0;
   bit          held_v[2];
   logic [7:0]  held_d[2];
   logic        held_c[2];
   bit          done_next[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic string h4(input logic [15:0] v, input bit lower);
      string s = "";
      for (int i = 3; i >= 0; i--) begin
         int d = int'(v[i*4 +: 4]);
         byte c = (d < 10) ? byte'(48 + d) : byte'((lower ? 97 : 65) + d - 10);
         s = {s, $sformatf("%c", c)};
      end
      return s;
   endfunction

   // Expected entry: {last beat, is command, byte}
   task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] r, input logic op);
      for (int d = 0; d < 2; d++) begin
         string l1, l2, opc;
         logic [9:0] q[$];
         opc = op ? "-" : "+";
         l1 = {"A=", h4(a, d == 1), " B=", h4(b, d == 1), "  ", opc};
         l2 = {"R=", h4(r, d == 1), "          "};
         q.push_back({2'b01, 8'h80});
         for (int i = 0; i < l1.len(); i++) q.push_back({2'b00, l1[i]});
         q.push_back({2'b01, 8'hC0});
         for (int i = 0; i < l2.len(); i++) q.push_back({(i == l2.len() - 1), 1'b0, l2[i]});
         foreach (q[i]) begin
            if (d == 0) exp_q0.push_back(q[i]);
            else        exp_q1.push_back(q[i]);
         end
      end
   endtask

   task automatic mon(input int d, input logic v, input logic [7:0] dat, input logic c,
                      input logic bsy, input logic dn);
      logic [9:0] e;
      int         qs;
      chk($sformatf("busy_eq_valid%0d", d), bsy, v);
      chk($sformatf("done%0d", d), dn, done_next[d]);
      done_next[d] = 0;
      if (held_v[d]) begin
         chk($sformatf("stall_valid%0d", d), v, 1'b1);
         chk($sformatf("stall_data%0d", d), dat, held_d[d]);
         chk($sformatf("stall_cmd%0d", d), c, held_c[d]);
      end
      if (v && char_ready) begin
         qs = (d == 0) ? exp_q0.size() : exp_q1.size();
         if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat%0d: got %0h expected no beat", d, dat);
         end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("beat_data%0d", d), dat, e[7:0]);
            chk($sformatf("beat_cmd%0d", d), c, e[8]);
            if (e[9]) done_next[d] = 1;
            if (d == 0) acc_cnt++;
         end
      end
      held_v[d] = v && !char_ready;
      held_d[d] = dat;
      held_c[d] = c;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         held_v[0] = 0; held_v[1] = 0;
         done_next[0] = 0; done_next[1] = 0;
      end else begin
         mon(0, val0, data0, cmd0, busy0, done0);
         mon(1, val1, data1, cmd1, busy1, done1);
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (!stall_en) begin
         char_ready = 1'b1;
      end else if (stall_left > 0) begin
         char_ready = 1'b0;
         stall_left--;
      end else if ($urandom_range(0, 2) == 0) begin
         char_ready = 1'b0;
         stall_left = int'($urandom_range(0, 4));
      end else begin
         char_ready = 1'b1;
      end
   end

   task automatic start_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input logic op);
      @(posedge clk); #1;
      A = a; B = b; R = r; operation = op;
      start = 1'b1;
      push_frame(a, b, r, op);
      frame_base = acc_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("first_valid_upper", val0, 1'b1);
      chk("first_valid_lower", val1, 1'b1);
   endtask

   task automatic wait_beats(input int k);
      bit ok = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 3000; i++) begin
         if (acc_cnt - frame_base >= k) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk($sformatf("reach_beat_%0d", k), ok, 1'b1);
   endtask

   task automatic wait_frame(input bit check_len);
      int vcnt = 1;
      bit seen = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (val0) vcnt++;
         if (done0) begin
            seen = 1;
            break;
         end
      end
      chk("done_seen", seen, 1'b1);
      if (check_len) chk("frame_cycles", vcnt, 34);
      chk("queue_empty_upper", exp_q0.size(), 0);
      chk("queue_empty_lower", exp_q1.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {val1, val0}, 2'b00);
      chk("rst_busy", {busy1, busy0}, 2'b00);
      chk("rst_done", {done1, done0}, 2'b00);
      chk("rst_cmd", {cmd1, cmd0}, 2'b00);
      chk("rst_data", {data1, data0}, 16'h0000);
      @(posedge clk); #1;
      reset = 1'b0;

      start_frame(16'h3C00, 16'h4000, 16'h4200, 1'b0);
      wait_frame(1);

      start_frame(16'hABCD, 16'h7BFF, 16'h9F0E, 1'b1);
      wait_frame(1);

      stall_en = 1;
      repeat (6) begin
         start_frame(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
         wait_frame(0);
      end
      stall_en = 0;

      start_frame(16'h1234, 16'h5678, 16'h9ABC, 1'b0);
      wait_beats(10);
      start = 1'b1; A = 16'hFFFF; B = 16'($urandom); operation = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_beats(33);
      start = 1'b1; R = 16'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      wait_frame(0);
      repeat (5) begin
         @(negedge clk);
         chk("idle_after_ignored_start", {val1, val0}, 2'b00);
      end

      start_frame(16'hC0DE, 16'hBEEF, 16'hF00D, 1'b1);
      wait_beats(20);
      reset = 1'b1;
      start = 1'b1;
      exp_q0.delete();
      exp_q1.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("abort_valid", {val1, val0}, 2'b00);
      chk("abort_busy", {busy1, busy0}, 2'b00);
      chk("abort_done", {done1, done0}, 2'b00);
      repeat (3) begin
         @(negedge clk);
         chk("abort_stays_idle", {val1, val0, done1, done0}, 4'b0000);
      end
      start_frame(16'h0001, 16'h8000, 16'h7C00, 1'b0);
      wait_frame(1);

      repeat (3) begin
         start_frame(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
         wait_frame(1);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
